pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2: instruction pipeline depth, legal range 2..8.
REQ-002 SHALL have parameter INSTR_WIDTH, default 8: opcode width.
REQ-003 SHALL have parameter FLAG_WIDTH, default 7: width of the ALU flags register.
REQ-004 SHALL have parameter HALT_OPCODE, default all-ones: opcode that halts the core on retirement.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST_bar, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port INSTR_IN, input, INSTR_WIDTH bits: instruction fetched from the memory data bus.
REQ-008 SHALL have port INSTR_VALID, input, 1 bit: INSTR_IN is valid this cycle.
REQ-009 SHALL have port INSTR_READY, output, 1 bit: the controller accepts INSTR_IN this cycle.
REQ-010 SHALL have port STALL, input, 1 bit: freeze all stages this cycle.
REQ-011 SHALL have port CANCEL, input, 1 bit: flush in-flight instructions (taken branch).
REQ-012 SHALL have port FLAGS_IN, input, FLAG_WIDTH bits: new flag values from the ALU.
REQ-013 SHALL have port FLAGS_LOAD, input, 1 bit: load the flags register.
REQ-014 SHALL have port FLAGS_OUT, output, FLAG_WIDTH bits: registered flags, fed back to the decode ROMs.
REQ-015 SHALL have port STAGE_OPCODE, output, NUM_STAGES*INSTR_WIDTH bits: stage k opcode at bits [k*INSTR_WIDTH +: INSTR_WIDTH].
REQ-016 SHALL have port STAGE_VALID, output, NUM_STAGES bits: stage k holds a real instruction, not a bubble.
REQ-017 SHALL have port HALT, output, 1 bit: core halted.

Function
REQ-018 SHALL implement FSM states IDLE, RUN and HALTED.
REQ-019 SHALL move IDLE->RUN on the first clock edge after RST_bar deasserts; INSTR_READY SHALL be low in IDLE.
REQ-020 SHALL drive INSTR_READY = (state==RUN) & !STALL & !CANCEL.
REQ-021 SHALL, in RUN with !STALL & !CANCEL: stage0 <= INSTR_IN with valid INSTR_VALID, or NOP (0) with valid 0 when INSTR_VALID is low; stage k <= stage k-1.
REQ-022 SHALL, on STALL in RUN with no CANCEL, hold all stage opcodes and valids unchanged.
REQ-023 SHALL give CANCEL priority over STALL: on CANCEL every stage becomes NOP with valid 0 on the same edge, and INSTR_IN is discarded.
REQ-024 SHALL move to HALTED when the last stage is valid, holds HALT_OPCODE and there is no STALL; the halting instruction SHALL be the last one retired.
REQ-025 SHALL assert HALT on the cycle after that edge and keep it asserted.
REQ-026 SHALL, in HALTED, freeze all stages, hold INSTR_READY low, and ignore CANCEL, STALL and FLAGS_LOAD.
REQ-027 SHALL leave HALTED only through reset.
REQ-028 SHALL, if CANCEL coincides with a retiring HALT_OPCODE, enter HALTED and flush the stages.
REQ-029 SHALL load FLAGS_IN into FLAGS_OUT at an edge only when FLAGS_LOAD=1, state==RUN and the last stage is valid.
REQ-030 SHALL drive outputs purely from registers, with no combinational path from inputs, except INSTR_READY.

Reset
REQ-031 SHALL, while RST_bar=0 (mid-operation included), immediately set: state IDLE, all stage opcodes 0, STAGE_VALID 0, FLAGS_OUT 0, HALT 0, INSTR_READY 0, and performance counters 0.

Configuration
REQ-032 SHALL, when PIPELINE_CONTROLLER_PERF_EN is defined, add 32-bit outputs RETIRED_COUNT (increments when a valid last stage advances or halts) and BUBBLE_COUNT (increments on each RUN cycle where the last stage is invalid or STALL=1); both saturate at 0xFFFFFFFF.
REQ-033 SHALL, when PIPELINE_CONTROLLER_PERF_EN is undefined, not have these ports or counters.

Structure
REQ-034 SHALL put the FSM state enum, the NOP opcode constant and the default HALT_OPCODE in the shared package pipeline_pkg.
REQ-035 SHALL instantiate one sub-module per stage, pipe_slot: an opcode+valid register with hold, flush and load controls.

Verification
REQ-036 SHALL check: reset, then INSTR_VALID=1 with INSTR_IN 0x11, 0x22, 0x33 on consecutive cycles at NUM_STAGES=2 -> stage1 shows 0x11 two edges after acceptance, STAGE_VALID=2'b11.
REQ-037 SHALL check: STALL=1 for 3 cycles with 0x22/0x11 in flight -> opcodes unchanged, INSTR_READY=0, then the pipeline resumes in order.
REQ-038 SHALL check: CANCEL and STALL asserted together with 0x22/0x11 in flight -> both stages 0x00, STAGE_VALID=0 the next cycle.
REQ-039 SHALL check: 0xFF enters the pipeline, reaches the last stage and retires -> HALT=1 one cycle later; further INSTR_VALID and CANCEL have no effect.
REQ-040 SHALL check: FLAGS_IN=7'h03, FLAGS_LOAD=1 with the last stage invalid -> FLAGS_OUT stays 0; with the last stage valid -> FLAGS_OUT=7'h03.
REQ-041 SHALL check: RST_bar pulsed low mid-stream at NUM_STAGES=4 -> all outputs 0 immediately, IDLE for one cycle, then INSTR_READY=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// the NOP opcode and the default halt opcode.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

    // Wide constants; users slice off the low INSTR_WIDTH bits.
    localparam logic [31:0] NOP_OPCODE          = 32'h0000_0000;
    localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_controller_pipe_slot.sv
// pipe_slot: one pipeline stage register (opcode + valid).
// Control priority: flush (load NOP, valid 0) > hold > load.
module pipe_slot
    import pipeline_pkg::*;
#(
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   hold,
    input  logic                   load,
    input  logic [INSTR_WIDTH-1:0] d_opcode,
    input  logic                   d_valid,
    output logic [INSTR_WIDTH-1:0] opcode,
    output logic                   valid
);

    logic [INSTR_WIDTH-1:0] opcode_q, opcode_d;
    logic                   valid_q, valid_d;

    // Next-state selection for the slot contents.
    always_comb begin
        opcode_d = opcode_q;
        valid_d  = valid_q;
        if (flush) begin
            opcode_d = NOP_OPCODE[INSTR_WIDTH-1:0];
            valid_d  = 1'b0;
        end else if (!hold && load) begin
            opcode_d = d_opcode;
            valid_d  = d_valid;
        end
    end

    // Slot register, cleared asynchronously to a NOP bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= NOP_OPCODE[INSTR_WIDTH-1:0];
            valid_q  <= 1'b0;
        end else begin
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
        end
    end

    assign opcode = opcode_q;
    assign valid  = valid_q;

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: instruction pipeline sequencer with stall, cancel
// (flush), flags register and halt-on-retire.
// Optional feature macro: PIPELINE_CONTROLLER_PERF_EN adds saturating
// RETIRED_COUNT / BUBBLE_COUNT performance counters.
// Handshake: an instruction is transferred on a rising edge where
// INSTR_VALID and INSTR_READY are both high; INSTR_READY does not depend
// on INSTR_VALID. When INSTR_VALID is low a NOP bubble enters stage 0.
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int                     NUM_STAGES  = 2,
    parameter int                     INSTR_WIDTH = 8,
    parameter int                     FLAG_WIDTH  = 7,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT[INSTR_WIDTH-1:0]
) (
    input  logic                              CLK,
    input  logic                              RST_bar,
    input  logic [INSTR_WIDTH-1:0]            INSTR_IN,
    input  logic                              INSTR_VALID,
    output logic                              INSTR_READY,
    input  logic                              STALL,
    input  logic                              CANCEL,
    input  logic [FLAG_WIDTH-1:0]             FLAGS_IN,
    input  logic                              FLAGS_LOAD,
    output logic [FLAG_WIDTH-1:0]             FLAGS_OUT,
    output logic [NUM_STAGES*INSTR_WIDTH-1:0] STAGE_OPCODE,
    output logic [NUM_STAGES-1:0]             STAGE_VALID,
    output logic                              HALT,
    output logic [1:0]                        STATE_DBG
`ifdef PIPELINE_CONTROLLER_PERF_EN
    ,
    output logic [31:0]                       RETIRED_COUNT,
    output logic [31:0]                       BUBBLE_COUNT
`endif
);

    ctrl_state_e            state_q, state_d;
    logic                   halt_q, halt_d;
    logic [FLAG_WIDTH-1:0]  flags_q, flags_d;

    logic [INSTR_WIDTH-1:0] slot_op [NUM_STAGES];
    logic [NUM_STAGES-1:0]  slot_valid;

    logic in_run, last_valid, halt_retire, flush_all, hold_all, advance;

    assign in_run      = (state_q == RUN);
    assign last_valid  = slot_valid[NUM_STAGES-1];
    // The halting instruction leaves the last stage on this edge; CANCEL
    // still flushes everything behind it.
    assign halt_retire = in_run && last_valid && !STALL &&
                         (slot_op[NUM_STAGES-1] == HALT_OPCODE);
    assign flush_all   = in_run && CANCEL;
    assign hold_all    = !in_run || STALL;
    assign advance     = in_run && !STALL && !CANCEL;

    assign INSTR_READY = advance;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_slot
            logic [INSTR_WIDTH-1:0] d_op;
            logic                   d_vld;
            if (k == 0) begin : g_head
                assign d_op  = INSTR_VALID ? INSTR_IN : NOP_OPCODE[INSTR_WIDTH-1:0];
                assign d_vld = INSTR_VALID;
            end else begin : g_tail
                assign d_op  = slot_op[k-1];
                assign d_vld = slot_valid[k-1];
            end
            pipe_slot #(.INSTR_WIDTH(INSTR_WIDTH)) u_slot (
                .clk      (CLK),
                .rst_n    (RST_bar),
                .flush    (flush_all),
                .hold     (hold_all),
                .load     (advance),
                .d_opcode (d_op),
                .d_valid  (d_vld),
                .opcode   (slot_op[k]),
                .valid    (slot_valid[k])
            );
            assign STAGE_OPCODE[k*INSTR_WIDTH +: INSTR_WIDTH] = slot_op[k];
        end
    endgenerate

    assign STAGE_VALID = slot_valid;

    // FSM next state and registered halt flag; HALTED is left only by reset.
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN: begin
                if (halt_retire) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Flags capture only for a real instruction at the end of the pipe.
    always_comb begin
        flags_d = flags_q;
        if (in_run && FLAGS_LOAD && last_valid) begin
            flags_d = FLAGS_IN;
        end
    end

    // FSM, halt and flags registers.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            flags_q <= flags_d;
        end
    end

    assign HALT      = halt_q;
    assign FLAGS_OUT = flags_q;
    assign STATE_DBG = state_q;

`ifdef PIPELINE_CONTROLLER_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] bubble_q, bubble_d;

    // Saturating event counters.
    always_comb begin
        retired_d = retired_q;
        bubble_d  = bubble_q;
        if (((advance && last_valid) || halt_retire) && (retired_q != 32'hFFFF_FFFF)) begin
            retired_d = retired_q + 32'd1;
        end
        if (in_run && (!last_valid || STALL) && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else begin
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    assign RETIRED_COUNT = retired_q;
    assign BUBBLE_COUNT  = bubble_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed testbench for pipeline_controller: a 2-stage instance for the
// main scenarios and a 4-stage instance for mid-stream reset and
// cancel-coinciding-with-halt.
module tb_pipeline_controller;

    logic clk;
    int   checks;
    int   errors;

    // 2-stage instance signals
    logic        rst2_n, v2, stall2, cancel2, fload2;
    logic [7:0]  in2;
    logic [6:0]  fin2, fout2;
    logic        ready2, halt2;
    logic [15:0] op2;
    logic [1:0]  vld2, st2;

    // 4-stage instance signals
    logic        rst4_n, v4, stall4, cancel4, fload4;
    logic [7:0]  in4;
    logic [6:0]  fin4, fout4;
    logic        ready4, halt4;
    logic [31:0] op4;
    logic [3:0]  vld4;
    logic [1:0]  st4;

`ifdef PIPELINE_CONTROLLER_PERF_EN
    logic [31:0] ret2, bub2, ret4, bub4;
`endif

    pipeline_controller #(.NUM_STAGES(2)) dut2 (
        .CLK(clk), .RST_bar(rst2_n), .INSTR_IN(in2), .INSTR_VALID(v2),
        .INSTR_READY(ready2), .STALL(stall2), .CANCEL(cancel2),
        .FLAGS_IN(fin2), .FLAGS_LOAD(fload2), .FLAGS_OUT(fout2),
        .STAGE_OPCODE(op2), .STAGE_VALID(vld2), .HALT(halt2), .STATE_DBG(st2)
`ifdef PIPELINE_CONTROLLER_PERF_EN
        , .RETIRED_COUNT(ret2), .BUBBLE_COUNT(bub2)
`endif
    );

    pipeline_controller #(.NUM_STAGES(4)) dut4 (
        .CLK(clk), .RST_bar(rst4_n), .INSTR_IN(in4), .INSTR_VALID(v4),
        .INSTR_READY(ready4), .STALL(stall4), .CANCEL(cancel4),
        .FLAGS_IN(fin4), .FLAGS_LOAD(fload4), .FLAGS_OUT(fout4),
        .STAGE_OPCODE(op4), .STAGE_VALID(vld4), .HALT(halt4), .STATE_DBG(st4)
`ifdef PIPELINE_CONTROLLER_PERF_EN
        , .RETIRED_COUNT(ret4), .BUBBLE_COUNT(bub4)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst2_n = 1'b0; rst4_n = 1'b0;
        v2 = 0; in2 = 0; stall2 = 0; cancel2 = 0; fin2 = 0; fload2 = 0;
        v4 = 0; in4 = 0; stall4 = 0; cancel4 = 0; fin4 = 0; fload4 = 0;
        #2;
        checks++; if (op2 !== 16'h0000) begin errors++; $display("FAIL reset_opcode got %h exp 0000", op2); end
        checks++; if (vld2 !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", vld2); end
        checks++; if (fout2 !== 7'h00 || halt2 !== 1'b0 || ready2 !== 1'b0) begin errors++;
            $display("FAIL reset_outs flags %h halt %b ready %b exp 0 0 0", fout2, halt2, ready2); end
        checks++; if (st2 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st2); end
        step();
        rst2_n = 1'b1; rst4_n = 1'b1;
        #1;
        checks++; if (ready2 !== 1'b0 || st2 !== 2'd0) begin errors++;
            $display("FAIL idle_after_reset ready %b state %0d exp 0 0", ready2, st2); end
        step();
        checks++; if (ready2 !== 1'b1 || st2 !== 2'd1) begin errors++;
            $display("FAIL run_after_idle ready %b state %0d exp 1 1", ready2, st2); end
    endtask

    task automatic test_fill();
        v2 = 1; in2 = 8'h11;
        step();
        checks++; if (op2 !== 16'h0011 || vld2 !== 2'b01) begin errors++;
            $display("FAIL fill_first op %h vld %b exp 0011 01", op2, vld2); end
        in2 = 8'h22;
        step();
        checks++; if (op2 !== 16'h1122 || vld2 !== 2'b11) begin errors++;
            $display("FAIL fill_second op %h vld %b exp 1122 11", op2, vld2); end
    endtask

    task automatic test_stall();
        in2 = 8'h33; v2 = 1; stall2 = 1;
        #1;
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", ready2); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (op2 !== 16'h1122 || vld2 !== 2'b11) begin errors++;
                $display("FAIL stall_hold cycle %0d op %h vld %b exp 1122 11", i, op2, vld2); end
        end
        stall2 = 0;
        #1;
        checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", ready2); end
        step();
        checks++; if (op2 !== 16'h2233 || vld2 !== 2'b11) begin errors++;
            $display("FAIL stall_resume op %h vld %b exp 2233 11", op2, vld2); end
        v2 = 0; in2 = 0;
        step();
        checks++; if (op2 !== 16'h3300 || vld2 !== 2'b10) begin errors++;
            $display("FAIL stall_bubble op %h vld %b exp 3300 10", op2, vld2); end
    endtask

    task automatic test_cancel();
        v2 = 1; in2 = 8'h11;
        step();
        in2 = 8'h22;
        step();
        checks++; if (op2 !== 16'h1122 || vld2 !== 2'b11) begin errors++;
            $display("FAIL cancel_setup op %h vld %b exp 1122 11", op2, vld2); end
        in2 = 8'h44; cancel2 = 1; stall2 = 1;
        #1;
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL cancel_ready got %b exp 0", ready2); end
        step();
        checks++; if (op2 !== 16'h0000 || vld2 !== 2'b00) begin errors++;
            $display("FAIL cancel_flush op %h vld %b exp 0000 00", op2, vld2); end
        cancel2 = 0; stall2 = 0; v2 = 0; in2 = 0;
    endtask

    task automatic test_flags();
        fin2 = 7'h03; fload2 = 1;
        step();
        checks++; if (fout2 !== 7'h00) begin errors++; $display("FAIL flags_invalid got %h exp 00", fout2); end
        fload2 = 0; v2 = 1; in2 = 8'h55;
        step();
        v2 = 0; in2 = 0;
        step();
        checks++; if (op2 !== 16'h5500 || vld2 !== 2'b10) begin errors++;
            $display("FAIL flags_setup op %h vld %b exp 5500 10", op2, vld2); end
        fload2 = 1;
        step();
        checks++; if (fout2 !== 7'h03) begin errors++; $display("FAIL flags_load got %h exp 03", fout2); end
        fload2 = 0;
    endtask

    task automatic test_halt();
        v2 = 1; in2 = 8'hFF;
        step();
        in2 = 8'h66;
        step();
        checks++; if (op2 !== 16'hFF66 || halt2 !== 1'b0) begin errors++;
            $display("FAIL halt_at_last op %h halt %b exp FF66 0", op2, halt2); end
        v2 = 0; in2 = 0;
        step();
        checks++; if (halt2 !== 1'b1 || st2 !== 2'd2) begin errors++;
            $display("FAIL halt_assert halt %b state %0d exp 1 2", halt2, st2); end
        checks++; if (op2 !== 16'h6600 || vld2 !== 2'b10) begin errors++;
            $display("FAIL halt_retire op %h vld %b exp 6600 10", op2, vld2); end
        v2 = 1; in2 = 8'h77; cancel2 = 1; fin2 = 7'h7F; fload2 = 1;
        #1;
        checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL halt_ready got %b exp 0", ready2); end
        step();
        step();
        checks++; if (op2 !== 16'h6600 || vld2 !== 2'b10) begin errors++;
            $display("FAIL halt_frozen op %h vld %b exp 6600 10", op2, vld2); end
        checks++; if (fout2 !== 7'h03 || halt2 !== 1'b1) begin errors++;
            $display("FAIL halt_sticky flags %h halt %b exp 03 1", fout2, halt2); end
        v2 = 0; in2 = 0; cancel2 = 0; fload2 = 0; fin2 = 0;
    endtask

    task automatic test_reset_mid();
        v4 = 1; in4 = 8'h01;
        step();
        in4 = 8'h02;
        step();
        in4 = 8'h03;
        step();
        in4 = 8'h04;
        step();
        checks++; if (op4 !== 32'h01020304 || vld4 !== 4'b1111) begin errors++;
            $display("FAIL mid_fill op %h vld %b exp 01020304 1111", op4, vld4); end
        v4 = 0; in4 = 0; fin4 = 7'h2A; fload4 = 1;
        step();
        checks++; if (fout4 !== 7'h2A || op4 !== 32'h02030400) begin errors++;
            $display("FAIL mid_flags flags %h op %h exp 2A 02030400", fout4, op4); end
        fload4 = 0; v4 = 1; in4 = 8'h09;
        #2;
        rst4_n = 1'b0;
        #1;
        checks++; if (op4 !== 32'h0 || vld4 !== 4'b0000 || fout4 !== 7'h00) begin errors++;
            $display("FAIL mid_reset_regs op %h vld %b flags %h exp 0 0 0", op4, vld4, fout4); end
        checks++; if (halt4 !== 1'b0 || ready4 !== 1'b0 || st4 !== 2'd0) begin errors++;
            $display("FAIL mid_reset_ctrl halt %b ready %b state %0d exp 0 0 0", halt4, ready4, st4); end
`ifdef PIPELINE_CONTROLLER_PERF_EN
        checks++; if (ret4 !== 32'd0 || bub4 !== 32'd0) begin errors++;
            $display("FAIL mid_reset_perf ret %0d bub %0d exp 0 0", ret4, bub4); end
`endif
        v4 = 0; in4 = 0;
        step();
        rst4_n = 1'b1;
        #1;
        checks++; if (ready4 !== 1'b0 || st4 !== 2'd0) begin errors++;
            $display("FAIL mid_idle ready %b state %0d exp 0 0", ready4, st4); end
        step();
        checks++; if (ready4 !== 1'b1 || st4 !== 2'd1) begin errors++;
            $display("FAIL mid_run ready %b state %0d exp 1 1", ready4, st4); end
    endtask

    task automatic test_cancel_halt();
        v4 = 1; in4 = 8'hFF;
        step();
        v4 = 0; in4 = 0;
        step();
        step();
        step();
        checks++; if (op4 !== 32'hFF000000 || vld4 !== 4'b1000) begin errors++;
            $display("FAIL ch_setup op %h vld %b exp FF000000 1000", op4, vld4); end
        cancel4 = 1;
        step();
        checks++; if (halt4 !== 1'b1 || st4 !== 2'd2) begin errors++;
            $display("FAIL ch_halt halt %b state %0d exp 1 2", halt4, st4); end
        checks++; if (op4 !== 32'h0 || vld4 !== 4'b0000) begin errors++;
            $display("FAIL ch_flush op %h vld %b exp 0 0", op4, vld4); end
        cancel4 = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_stall();
        test_cancel();
        test_flags();
        test_halt();
        test_reset_mid();
        test_cancel_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
